// File: rtl/max_pool_2x2_stream.sv
// ============================================================================
// Module  : max_pool_2x2_stream
// Brief   : 2x2 / stride-2 max pooling on a raster-order sample stream,
//           buffering only half a row of horizontal pair maxima.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module max_pool_2x2_stream #(
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 12,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] In_OFM,
    output logic              out_valid,
    output logic [DATA_W-1:0] Out_Pool,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROW_A = 2'd1,
        S_ROW_B = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DATA_W-1:0]   h_max_q;
    logic [DATA_W-1:0]   lb_q [LB_D];
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_pool_q, out_pool_d;
    logic                frame_done_q, frame_done_d;

    logic                w_col_last;
    logic                w_row_last;
    logic                w_odd_col;
    logic                w_odd_row;
    logic [LB_AW-1:0]    w_lb_idx;
    logic [DATA_W-1:0]   w_pair;
    logic [DATA_W-1:0]   w_lb_rd;
    logic [DATA_W-1:0]   w_win;

    assign w_col_last = (col_q == COL_W'(IMG_W - 1));
    assign w_row_last = (row_q == ROW_W'(IMG_H - 1));
    assign w_odd_col  = col_q[0];
    // The FSM tracks row parity; ROW_B is exactly the odd-row phase.
    assign w_odd_row  = (state_q == S_ROW_B);
    assign w_lb_idx   = LB_AW'(col_q >> 1);
    assign w_pair     = (In_OFM > h_max_q) ? In_OFM : h_max_q;
    assign w_lb_rd    = lb_q[w_lb_idx];
    assign w_win      = (w_lb_rd > w_pair) ? w_lb_rd : w_pair;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        out_pool_d   = out_pool_q;
        frame_done_d = 1'b0;
        if (in_valid) begin
            if (w_col_last) begin
                col_d = '0;
                row_d = w_row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            case (state_q)
                S_IDLE:  state_d = S_ROW_A;
                S_ROW_A: if (w_col_last) state_d = S_ROW_B;
                S_ROW_B: if (w_col_last) state_d = w_row_last ? S_IDLE : S_ROW_A;
                default: state_d = S_IDLE;
            endcase
            if (w_odd_col && w_odd_row) begin
                out_valid_d  = 1'b1;
                out_pool_d   = w_win;
                frame_done_d = w_col_last && w_row_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            h_max_q      <= '0;
            out_valid_q  <= 1'b0;
            out_pool_q   <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < LB_D; i++) begin
                lb_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_pool_q   <= out_pool_d;
            frame_done_q <= frame_done_d;
            if (in_valid && !w_odd_col) begin
                h_max_q <= In_OFM;
            end
            if (in_valid && w_odd_col && !w_odd_row) begin
                lb_q[w_lb_idx] <= w_pair;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign Out_Pool   = out_pool_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2_stream.sv
// ============================================================================
// Module  : tb_max_pool_2x2_stream
// Brief   : Self-checking bench for max_pool_2x2_stream using a frame-array
//           reference model, a window vector table and directed sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_max_pool_2x2_stream;

    localparam int W    = 12;
    localparam int H    = 12;
    localparam int DW   = 36;
    localparam int NPIX = W * H;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] In_OFM   = '0;
    logic          out_valid;
    logic [DW-1:0] Out_Pool;
    logic          frame_done;

    always #5 clk = ~clk;

    max_pool_2x2_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .In_OFM     (In_OFM),
        .out_valid  (out_valid),
        .Out_Pool   (Out_Pool),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [DW-1:0] tl;
        logic [DW-1:0] tr;
        logic [DW-1:0] bl;
        logic [DW-1:0] br;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tbl [7];
    int            checks      = 0;
    int            failures    = 0;
    int            n           = 0;
    logic [DW-1:0] pix [NPIX];
    int            out_cnt     = 0;
    int            fd_cnt      = 0;
    int            acc_total   = 0;
    int            fd_pos_last = -1;
    int            fd_interval = 0;
    logic [DW-1:0] cap_first   = '0;
    logic [DW-1:0] cap16       = '0;
    logic [DW-1:0] cap_last    = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // One clock cycle: drive inputs, predict from the stored frame, check after the edge.
    task automatic step(input logic v, input logic [DW-1:0] d);
        logic          ev;
        logic          efd;
        logic [DW-1:0] ed;
        int            r;
        int            c;
        ev  = 1'b0;
        efd = 1'b0;
        ed  = '0;
        in_valid = v;
        In_OFM   = d;
        if (v) begin
            r = n / W;
            c = n % W;
            pix[n] = d;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                ev = 1'b1;
                ed = mx(mx(pix[n-W-1], pix[n-W]), mx(pix[n-1], pix[n]));
            end
            efd = (n == NPIX - 1);
            n   = efd ? 0 : n + 1;
            acc_total++;
        end
        @(posedge clk);
        #1;
        check("out_valid", DW'(out_valid), DW'(ev));
        check("frame_done", DW'(frame_done), DW'(efd));
        if (ev) check("Out_Pool", Out_Pool, ed);
        if (out_valid) begin
            if (out_cnt == 0)  cap_first = Out_Pool;
            if (out_cnt == 15) cap16 = Out_Pool;
            cap_last = Out_Pool;
            out_cnt++;
        end
        if (frame_done) begin
            if (fd_pos_last >= 0) fd_interval = acc_total - fd_pos_last;
            fd_pos_last = acc_total;
            fd_cnt++;
        end
    endtask

    task automatic start_frame();
        out_cnt     = 0;
        fd_cnt      = 0;
        fd_pos_last = -1;
        fd_interval = 0;
    endtask

    task automatic ramp(input int base);
        for (int i = 0; i < NPIX; i++) step(1'b1, DW'(base + i));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, DW'(out_valid), '0);
        check({tag, "_Out_Pool"}, Out_Pool, '0);
        check({tag, "_frame_done"}, DW'(frame_done), '0);
    endtask

    initial begin
        int idx;
        logic [DW-1:0] v;

        tbl[0] = '{36'd1000, 36'd5, 36'd5, 36'd5, 36'd1000};
        tbl[1] = '{36'd5, 36'd1000, 36'd5, 36'd5, 36'd1000};
        tbl[2] = '{36'd5, 36'd5, 36'd1000, 36'd5, 36'd1000};
        tbl[3] = '{36'd5, 36'd5, 36'd5, 36'd1000, 36'd1000};
        tbl[4] = '{36'hFFFFFFFFE, 36'hFFFFFFFFF, 36'hFFFFFFFFE, 36'hFFFFFFFFE, 36'hFFFFFFFFF};
        tbl[5] = '{36'h0FFFFFFFF, 36'h0FFFFFFFF, 36'h800000000, 36'h0FFFFFFFF, 36'h800000000};
        tbl[6] = '{36'd7, 36'd7, 36'd7, 36'd7, 36'd7};

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous ramp
        start_frame();
        ramp(0);
        check("ramp_count", DW'(out_cnt), DW'(36));
        check("ramp_frame_done_count", DW'(fd_cnt), DW'(1));
        check("ramp_first", cap_first, DW'(13));
        check("ramp_last", cap_last, DW'(143));

        // Window (2,3) position sweep and full-width vectors
        foreach (tbl[e]) begin
            start_frame();
            for (int i = 0; i < NPIX; i++) begin
                v = DW'(5);
                if (i == 4*W + 6) v = tbl[e].tl;
                if (i == 4*W + 7) v = tbl[e].tr;
                if (i == 5*W + 6) v = tbl[e].bl;
                if (i == 5*W + 7) v = tbl[e].br;
                step(1'b1, v);
            end
            check("sweep_win23", cap16, tbl[e].exp);
            check("sweep_count", DW'(out_cnt), DW'(36));
        end

        // Ramp with random gaps
        start_frame();
        idx = 0;
        for (int cyc = 0; cyc < 4000 && idx < NPIX; cyc++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, DW'(idx));
                idx++;
            end else begin
                step(1'b0, DW'($urandom));
            end
        end
        check("gap_samples_fed", DW'(idx), DW'(NPIX));
        check("gap_count", DW'(out_cnt), DW'(36));
        check("gap_first", cap_first, DW'(13));
        check("gap_last", cap_last, DW'(143));

        // Back-to-back frames
        start_frame();
        ramp(0);
        ramp(1000);
        check("b2b_count", DW'(out_cnt), DW'(72));
        check("b2b_frame_done_count", DW'(fd_cnt), DW'(2));
        check("b2b_frame_done_spacing", DW'(fd_interval), DW'(NPIX));
        check("b2b_last", cap_last, DW'(1143));

        // Reset in the middle of a frame
        start_frame();
        for (int i = 0; i <= 70; i++) step(1'b1, DW'(i));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        start_frame();
        ramp(0);
        check("midrst_count", DW'(out_cnt), DW'(36));
        check("midrst_first", cap_first, DW'(13));
        check("midrst_last", cap_last, DW'(143));

        // Random data with random gaps
        start_frame();
        idx = 0;
        for (int cyc = 0; cyc < 4000 && idx < NPIX; cyc++) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, DW'({$urandom, $urandom}));
                idx++;
            end else begin
                step(1'b0, '0);
            end
        end
        check("rand_count", DW'(out_cnt), DW'(36));
        check("rand_frame_done_count", DW'(fd_cnt), DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
